// File: rtl/program_load_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// program_load_sequencer_pkg
//
// Shared definitions for the program load sequencer and its byte packer.
//   - State encodings for the load FSM, kept as plain localparam constants so
//     existing code that compares raw state values keeps working.
//   - Byte ordering of the incoming program stream (little-endian).
//   - Helpers for the header word limit and header validation.
// -----------------------------------------------------------------------------
package program_load_sequencer_pkg;

    // Load FSM state encodings
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_HDR   = 3'd1;
    localparam state_t ST_BYTES = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_ERR   = 3'd4;

    // Order in which the four bytes of an instruction arrive on the UART
    typedef enum logic {
        BYTE_ORDER_LITTLE = 1'b0,
        BYTE_ORDER_BIG    = 1'b1
    } byte_order_t;

    localparam byte_order_t BYTE_ORDER = BYTE_ORDER_LITTLE;

    // Largest word count a header may announce: the whole instruction memory
    function automatic int hdr_max_words(input int addr_width);
        return 1 << addr_width;
    endfunction

    // A header is usable when it asks for at least one word and no more
    // words than the instruction memory holds
    function automatic logic header_ok(input logic [7:0] n, input int max_words);
        return (n != 8'd0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/program_load_sequencer_byte_word_packer.sv
// -----------------------------------------------------------------------------
// program_load_sequencer_byte_word_packer
//
// Collects UART bytes into 32-bit instruction words.
//
// Ports:
//   clk         system clock
//   rst         asynchronous, active-high reset
//   clear       drops any partial word and restarts at byte 0 (wins over
//               byte_valid in the same cycle)
//   byte_valid  byte_in holds a byte to accept this cycle
//   byte_in     incoming byte
//   word_out    the word as it looks including this cycle's byte; only
//               meaningful while word_valid is high
//   word_valid  high in the cycle the fourth byte of a word is accepted
//
// word_out/word_valid are combinational so the parent can register the
// memory write on the same edge that takes the last byte, which keeps the
// write exactly one cycle after the fourth byte.
// -----------------------------------------------------------------------------
module program_load_sequencer_byte_word_packer
    import program_load_sequencer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [31:0] partial_word;
    logic [1:0]  byte_idx;
    logic [1:0]  lane;
    logic        accept;

    // Merge the current byte into the partial word at the lane chosen by the
    // byte order, and flag completion when the fourth byte goes in.
    always_comb begin
        accept     = byte_valid && !clear;
        lane       = (BYTE_ORDER == BYTE_ORDER_LITTLE) ? byte_idx : (2'd3 - byte_idx);
        word_out   = partial_word;
        word_out[8*lane +: 8] = byte_in;
        word_valid = accept && (byte_idx == 2'd3);
    end

    // Hold the bytes gathered so far. After a full word the partial word is
    // emptied so the next word starts clean; the index wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            partial_word <= '0;
            byte_idx     <= '0;
        end else if (clear) begin
            partial_word <= '0;
            byte_idx     <= '0;
        end else if (accept) begin
            partial_word <= (byte_idx == 2'd3) ? 32'd0 : word_out;
            byte_idx     <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/program_load_sequencer.sv
// -----------------------------------------------------------------------------
// program_load_sequencer
//
// Boot/load controller between the UART receiver and the instruction memory.
// Holds the CPU pipeline in reset, receives a framed program (one header byte
// with the word count N, then 4*N little-endian bytes), writes each word into
// instruction memory and then releases the pipeline.
//
// Parameters:
//   ADDR_WIDTH      instruction-memory address width (DEPTH = 2**ADDR_WIDTH)
//   TIMEOUT_CYCLES  idle cycles allowed between bytes once words are flowing
//   CNT_WIDTH       width of the idle-cycle counter
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   i_rx_valid       one-cycle pulse, i_rx_byte holds a new UART byte
//   i_rx_byte        received byte
//   i_start_load     one-cycle pulse, begin or restart a load
//   o_write_enable   one-cycle instruction-memory write strobe
//   o_address        write word address
//   o_instruction    write data
//   o_cpu_rst        pipeline held in reset while high
//   o_run            program loaded and pipeline running
//   o_busy           load in progress (header or byte phase)
//   o_error          sticky load error (bad header or stalled transfer)
//   o_words_loaded   words written during the current load
//
// Every output is a register.
// -----------------------------------------------------------------------------
module program_load_sequencer
    import program_load_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_WIDTH      = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx_valid,
    input  logic [7:0]            i_rx_byte,
    input  logic                  i_start_load,
    output logic                  o_write_enable,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [31:0]           o_instruction,
    output logic                  o_cpu_rst,
    output logic                  o_run,
    output logic                  o_busy,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_words_loaded
);

    localparam int NW_WIDTH      = ADDR_WIDTH + 1;
    localparam int HDR_MAX_WORDS = hdr_max_words(ADDR_WIDTH);

    // Counter value at which one more idle cycle exhausts the allowance
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] word_ptr;
    logic [NW_WIDTH-1:0]   num_words;
    logic [CNT_WIDTH-1:0]  timeout_cnt;

    logic                  packer_clear;
    logic                  packer_valid;
    logic                  word_valid;
    logic [31:0]           packed_word;

    logic                  hdr_byte;
    logic                  hdr_ok;
    logic                  last_word;
    logic                  timeout_hit;

    // Byte packer: only listens while in the byte phase. A start pulse or any
    // other state clears it, which is also how a partial word gets thrown
    // away on restart, timeout or header errors.
    program_load_sequencer_byte_word_packer u_byte_word_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_valid (packer_valid),
        .byte_in    (i_rx_byte),
        .word_out   (packed_word),
        .word_valid (word_valid)
    );

    // Next-state logic. A start pulse overrides everything, including a byte
    // arriving in the same cycle, so that byte is simply lost. The last word
    // and the timeout can never coincide because the timeout needs an idle
    // cycle while the last word needs a byte.
    always_comb begin
        packer_clear = i_start_load || (state != ST_BYTES);
        packer_valid = i_rx_valid && (state == ST_BYTES);
        hdr_byte     = (state == ST_HDR) && i_rx_valid && !i_start_load;
        hdr_ok       = header_ok(i_rx_byte, HDR_MAX_WORDS);
        last_word    = word_valid && ({1'b0, word_ptr} == (num_words - NW_WIDTH'(1)));
        timeout_hit  = (state == ST_BYTES) && !i_start_load && !i_rx_valid &&
                       (timeout_cnt == TIMEOUT_LAST);

        state_next = state;
        if (i_start_load) begin
            state_next = ST_HDR;
        end else begin
            case (state)
                ST_HDR: begin
                    if (hdr_byte) begin
                        state_next = hdr_ok ? ST_BYTES : ST_ERR;
                    end
                end
                ST_BYTES: begin
                    if (last_word) begin
                        state_next = ST_RUN;
                    end else if (timeout_hit) begin
                        state_next = ST_ERR;
                    end
                end
                ST_IDLE, ST_RUN, ST_ERR: begin
                    state_next = state;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Word count from the header and the write pointer. The pointer moves
    // with every completed word; since the load ends after word N-1 the
    // pointer never addresses beyond the announced program.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_words <= '0;
            word_ptr  <= '0;
        end else if (i_start_load) begin
            num_words <= '0;
            word_ptr  <= '0;
        end else if (hdr_byte && hdr_ok) begin
            num_words <= NW_WIDTH'(i_rx_byte);
            word_ptr  <= '0;
        end else if (word_valid) begin
            word_ptr <= word_ptr + 1'b1;
        end
    end

    // Idle-cycle counter. It only runs while we stay in the byte phase with no
    // byte arriving; any byte, any state change or the header phase keeps it
    // at zero, so waiting for the header can never time out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt <= '0;
        end else if ((state == ST_BYTES) && (state_next == ST_BYTES) && !i_rx_valid) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end else begin
            timeout_cnt <= '0;
        end
    end

    // Instruction-memory write port. The strobe is a single cycle following
    // the fourth byte; address and data hold their last values afterwards.
    // A strobe already on the port still finishes if a restart arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_write_enable <= 1'b0;
            o_address      <= '0;
            o_instruction  <= '0;
        end else begin
            o_write_enable <= word_valid;
            if (word_valid) begin
                o_address     <= word_ptr;
                o_instruction <= packed_word;
            end
        end
    end

    // Count of words written in the current load, cleared by every start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_words_loaded <= '0;
        end else if (i_start_load) begin
            o_words_loaded <= '0;
        end else if (word_valid) begin
            o_words_loaded <= o_words_loaded + 1'b1;
        end
    end

    // Status flags follow the state we are moving into, except for the
    // pipeline release: o_cpu_rst/o_run only change once we have already
    // spent a cycle in RUN, so the final memory write lands before the CPU
    // leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_busy    <= 1'b0;
            o_error   <= 1'b0;
            o_run     <= 1'b0;
            o_cpu_rst <= 1'b1;
        end else begin
            o_busy    <= (state_next == ST_HDR) || (state_next == ST_BYTES);
            o_error   <= (state_next == ST_ERR);
            o_run     <= (state == ST_RUN) && (state_next == ST_RUN);
            o_cpu_rst <= !((state == ST_RUN) && (state_next == ST_RUN));
        end
    end

endmodule

// File: doc/program_load_sequencer.md
Name: program_load_sequencer

Overview:
Boot/load controller that sits between the UART receiver and the instruction path (instructionLoad → instructionFetch). It holds the pipeline in reset and accepts a framed program from UART: one header byte with the word count N, then 4·N bytes, little-endian. It writes each assembled word into instruction memory using the existing write-enable/address/instruction interface, then releases the pipeline to run. Error handling covers bad headers and stalled transfers.

Parameters:
ADDR_WIDTH, 3, instruction-memory address width; DEPTH = 2**ADDR_WIDTH words
TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes once a load is in progress
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
i_rx_valid  input  1  one-cycle pulse: i_rx_byte holds a new UART byte
i_rx_byte  input  8  received byte
i_start_load  input  1  one-cycle pulse: begin or restart a load
o_write_enable  output  1  one-cycle instruction-memory write strobe
o_address  output  ADDR_WIDTH  write word address
o_instruction  output  32  write data
o_cpu_rst  output  1  high = pipeline held in reset
o_run  output  1  program loaded, pipeline running
o_busy  output  1  load in progress (HDR or BYTES)
o_error  output  1  sticky load error
o_words_loaded  output  ADDR_WIDTH+1  count of words written in current load

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; o_write_enable=0, o_address=0, o_instruction=0, o_cpu_rst=1, o_run=0, o_busy=0, o_error=0, o_words_loaded=0. Internal byte_idx, word_ptr and timeout counter are also 0.
- States: IDLE, HDR, BYTES, RUN, ERR. All outputs are registered.
- IDLE: i_start_load → HDR. Bytes are ignored.
- HDR: on i_rx_valid, latch N=i_rx_byte.
  - 1≤N≤DEPTH → BYTES, with word_ptr=0 and byte_idx=0.
  - N=0 or N>DEPTH → ERR.
- BYTES: each i_rx_valid writes word[8*byte_idx +: 8] and increments byte_idx mod 4.
  - When the 4th byte is accepted (cycle T), at T+1: o_write_enable=1 for exactly one cycle, o_address=word_ptr, o_instruction=assembled word, o_words_loaded increments.
  - word_ptr increments at T+1.
  - Bytes are accepted on every cycle, including the write-pulse cycle; no byte loss at any rate up to 1 byte/cycle.
  - If the word just written has word_ptr==N-1: → RUN at T+1, o_cpu_rst falls at T+2 (after the write completes), o_run rises at T+2.
- RUN: i_rx_valid ignored. i_start_load → HDR; o_cpu_rst=1 and o_run=0 the next cycle; o_words_loaded and o_error cleared.
- Timeout: in HDR/BYTES, the counter resets on each i_rx_valid. It is also held at 0 in HDR before the first byte (no timeout waiting for the header). Reaching TIMEOUT_CYCLES → ERR; any partial word is discarded with no write.
- ERR: o_error=1 (sticky), o_cpu_rst=1, o_busy=0. Only i_start_load exits (→ HDR, clears o_error).
- i_start_load in HDR/BYTES: restart at HDR; pointers and partial word cleared. An in-flight write pulse from the previous cycle still completes.
- Simultaneous i_start_load and i_rx_valid: start wins; the byte is dropped.
- Address wrap: impossible by construction (N≤DEPTH). o_address never exceeds N-1.
- Reset mid-load: immediate return to reset values. Memory contents are left untouched.
- o_busy=1 exactly in HDR and BYTES.

Decomposition:
- Shared package: state enum (IDLE/HDR/BYTES/RUN/ERR), a HDR_MAX_WORDS constant derived from DEPTH, and the byte-order constant (little-endian).
- One natural sub-module, byte_word_packer: takes byte and valid, outputs a 32-bit word plus a word_valid pulse, with a clear input.
- The FSM, timeout counter and write-port register remain in the top level.

Test Plan:
- Load N=1, bytes 33 02 21 00 → one write pulse: addr 0, data 0x00210233; o_cpu_rst falls 2 cycles after the 4th byte; o_run=1; o_words_loaded=1.
- Load N=8, back-to-back bytes every cycle → 8 write pulses at addr 0..7, none lost; the last write precedes the o_cpu_rst fall by 1 cycle.
- Header 0x00, then separately a header 0x09 (DEPTH=8) → ERR, o_error=1, no writes, o_cpu_rst stays 1; i_start_load clears o_error.
- TIMEOUT_CYCLES=16, N=2, send 6 bytes then stall → o_error asserts exactly 16 cycles after the last byte; only addr 0 is written.
- In RUN, pulse i_start_load together with i_rx_valid → byte dropped; o_cpu_rst=1, o_run=0 next cycle; a new N=1 load succeeds.
- Assert rst midway through word 2 → all outputs return to reset values asynchronously; no further write pulses.
